// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind scorer: FSM states, peg
// extraction from packed code/guess vectors, and counter width helpers.
package mastermind_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        RED,
        WHITE,
        DONE,
        OVER
    } state_t;

    // Upper bounds for the generic peg extractor; callers zero-extend into these.
    localparam int MAX_VEC_W   = 256;
    localparam int MAX_COLOR_W = 16;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_COLOR_W-1:0] get_peg(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   idx,
        input int                   color_w
    );
        logic [MAX_COLOR_W-1:0] mask;
        mask = {MAX_COLOR_W{1'b1}} >> (MAX_COLOR_W - color_w);
        return MAX_COLOR_W'(vec >> (idx * color_w)) & mask;
    endfunction

endpackage

// File: rtl/mastermind_peg_finder.sv
// Combinational priority search: lowest unused guess peg whose colour
// equals the target colour.
module mastermind_peg_finder import mastermind_pkg::*; #(
    parameter  int NUM_PEGS = 4,
    parameter  int COLOR_W  = 3,
    localparam int IDX_W    = idx_width(NUM_PEGS)
) (
    input  logic [COLOR_W-1:0]          target,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess_vec,
    input  logic [NUM_PEGS-1:0]         used,
    output logic                        found,
    output logic [IDX_W-1:0]            index
);

    // Scanning downwards lets the lowest matching index win.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int j = NUM_PEGS - 1; j >= 0; j--) begin
            if (!used[j] && (guess_vec[j*COLOR_W +: COLOR_W] == target)) begin
                found = 1'b1;
                index = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mastermind_scorer_n.sv
// Parametrised Mastermind engine: holds the secret code, scores guesses
// sequentially (exact pass, then colour pass) and tracks win/lose.
module mastermind_scorer_n import mastermind_pkg::*; #(
    parameter  int NUM_PEGS    = 4,
    parameter  int COLOR_W     = 3,
    parameter  int MAX_GUESSES = 8,
    localparam int CNT_W       = cnt_width(NUM_PEGS),
    localparam int GC_W        = cnt_width(MAX_GUESSES),
    localparam int IDX_W       = idx_width(NUM_PEGS),
    localparam int VEC_W       = NUM_PEGS * COLOR_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             code_valid,
    input  logic [VEC_W-1:0] code_in,
    input  logic             guess_valid,
    input  logic [VEC_W-1:0] guess_in,
    output logic             guess_ready,
    output logic             score_valid,
    output logic [CNT_W-1:0] red,
    output logic [CNT_W-1:0] white,
    output logic [GC_W-1:0]  guess_count,
    output logic             win,
    output logic             lose,
    output logic             busy
);

    state_t                 state_q, state_d;
    logic [VEC_W-1:0]       code_q, guess_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_PEGS-1:0]    used_code_q, used_guess_q;
    logic [CNT_W-1:0]       red_acc, white_acc;
    logic [MAX_COLOR_W-1:0] code_peg, guess_peg;
    logic                   find_hit;
    logic [IDX_W-1:0]       find_idx;
    logic                   last_idx, all_red, final_guess;

    assign code_peg    = get_peg(MAX_VEC_W'(code_q), int'(idx_q), COLOR_W);
    assign guess_peg   = get_peg(MAX_VEC_W'(guess_q), int'(idx_q), COLOR_W);
    assign last_idx    = (idx_q == IDX_W'(NUM_PEGS - 1));
    assign all_red     = (red_acc == CNT_W'(NUM_PEGS));
    assign final_guess = ((guess_count + GC_W'(1)) == GC_W'(MAX_GUESSES));

    mastermind_peg_finder #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W)
    ) u_finder (
        .target    (code_peg[COLOR_W-1:0]),
        .guess_vec (guess_q),
        .used      (used_guess_q),
        .found     (find_hit),
        .index     (find_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        guess_ready = 1'b0;
        busy        = 1'b0;
        case (state_q)
            READY: begin
                guess_ready = 1'b1;
                if (guess_valid) state_d = RED;
            end
            RED: begin
                busy = 1'b1;
                if (last_idx) state_d = WHITE;
            end
            WHITE: begin
                busy = 1'b1;
                if (last_idx) state_d = DONE;
            end
            DONE:    state_d = (all_red || final_guess) ? OVER : READY;
            default: state_d = state_q;
        endcase
        // A new code restarts the game from any state, aborting a scoring pass.
        if (code_valid) state_d = READY;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            code_q       <= '0;
            guess_q      <= '0;
            idx_q        <= '0;
            used_code_q  <= '0;
            used_guess_q <= '0;
            red_acc      <= '0;
            white_acc    <= '0;
            red          <= '0;
            white        <= '0;
            score_valid  <= 1'b0;
            guess_count  <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else if (code_valid) begin
            code_q       <= code_in;
            idx_q        <= '0;
            used_code_q  <= '0;
            used_guess_q <= '0;
            red_acc      <= '0;
            white_acc    <= '0;
            red          <= '0;
            white        <= '0;
            score_valid  <= 1'b0;
            guess_count  <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            case (state_q)
                READY: begin
                    if (guess_valid) begin
                        guess_q      <= guess_in;
                        idx_q        <= '0;
                        used_code_q  <= '0;
                        used_guess_q <= '0;
                        red_acc      <= '0;
                        white_acc    <= '0;
                    end
                end
                RED: begin
                    if (code_peg == guess_peg) begin
                        used_code_q[idx_q]  <= 1'b1;
                        used_guess_q[idx_q] <= 1'b1;
                        red_acc             <= red_acc + CNT_W'(1);
                    end
                    idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
                end
                WHITE: begin
                    // Pegs already matched exactly take no part in colour matching.
                    if (!used_code_q[idx_q] && find_hit) begin
                        used_guess_q[find_idx] <= 1'b1;
                        white_acc              <= white_acc + CNT_W'(1);
                    end
                    idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
                end
                DONE: begin
                    red         <= red_acc;
                    white       <= white_acc;
                    score_valid <= 1'b1;
                    guess_count <= guess_count + GC_W'(1);
                    if (all_red)          win  <= 1'b1;
                    else if (final_guess) lose <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_scorer_n.sv
// Self-checking bench for mastermind_scorer_n: directed table, corner-case
// sequences and randomized guesses against a counting-based reference model.
module tb_mastermind_scorer_n;

    localparam int NA = 4, CA = 3, NB = 6, CB = 4, MG = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0;
    logic        a_code_valid = 1'b0, a_guess_valid = 1'b0;
    logic [11:0] a_code_in = '0, a_guess_in = '0;
    logic        a_guess_ready, a_score_valid, a_win, a_lose, a_busy;
    logic [2:0]  a_red, a_white;
    logic [3:0]  a_gc;

    logic        b_code_valid = 1'b0, b_guess_valid = 1'b0;
    logic [23:0] b_code_in = '0, b_guess_in = '0;
    logic        b_guess_ready, b_score_valid, b_win, b_lose, b_busy;
    logic [2:0]  b_red, b_white;
    logic [3:0]  b_gc;

    mastermind_scorer_n #(.NUM_PEGS(NA), .COLOR_W(CA), .MAX_GUESSES(MG)) dut_a (
        .clk(clk), .resetn(resetn), .code_valid(a_code_valid), .code_in(a_code_in),
        .guess_valid(a_guess_valid), .guess_in(a_guess_in), .guess_ready(a_guess_ready),
        .score_valid(a_score_valid), .red(a_red), .white(a_white), .guess_count(a_gc),
        .win(a_win), .lose(a_lose), .busy(a_busy)
    );

    mastermind_scorer_n #(.NUM_PEGS(NB), .COLOR_W(CB), .MAX_GUESSES(MG)) dut_b (
        .clk(clk), .resetn(resetn), .code_valid(b_code_valid), .code_in(b_code_in),
        .guess_valid(b_guess_valid), .guess_in(b_guess_in), .guess_ready(b_guess_ready),
        .score_valid(b_score_valid), .red(b_red), .white(b_white), .guess_count(b_gc),
        .win(b_win), .lose(b_lose), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: red = positional matches, white = shared colours minus red.
    function automatic int peg(input logic [23:0] v, input int i, input int cw);
        logic [23:0] m;
        m = (24'd1 << cw) - 24'd1;
        return int'((v >> (i * cw)) & m);
    endfunction

    function automatic void ref_score(input logic [23:0] code, input logic [23:0] guess,
                                      input int n, input int cw, output int r, output int w);
        int hc[16];
        int hg[16];
        int common;
        r = 0;
        common = 0;
        for (int k = 0; k < 16; k++) begin
            hc[k] = 0;
            hg[k] = 0;
        end
        for (int i = 0; i < n; i++) begin
            if (peg(code, i, cw) == peg(guess, i, cw)) r++;
            hc[peg(code, i, cw)]++;
            hg[peg(guess, i, cw)]++;
        end
        for (int k = 0; k < 16; k++) common += (hc[k] < hg[k]) ? hc[k] : hg[k];
        w = common - r;
    endfunction

    function automatic logic [23:0] p4(input int a, input int b, input int c, input int d);
        logic [2:0] x0, x1, x2, x3;
        x0 = a[2:0]; x1 = b[2:0]; x2 = c[2:0]; x3 = d[2:0];
        return {12'd0, x3, x2, x1, x0};
    endfunction

    function automatic logic [23:0] rnd_vec(input int n, input int cw, input int maxc);
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (24'($urandom_range(0, maxc)) << (i * cw));
        return v;
    endfunction

    function automatic bit rdy(input bit sel);
        return sel ? b_guess_ready : a_guess_ready;
    endfunction

    function automatic bit sv(input bit sel);
        return sel ? b_score_valid : a_score_valid;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_code(input bit sel, input logic [23:0] c);
        if (sel) begin b_code_in = c; b_code_valid = 1'b1; end
        else     begin a_code_in = c[11:0]; a_code_valid = 1'b1; end
        tick();
        a_code_valid = 1'b0;
        b_code_valid = 1'b0;
    endtask

    // Waits (bounded) for guess_ready, then presents the guess for one accept edge.
    task automatic offer(input bit sel, input logic [23:0] g, input string nm);
        int n = 0;
        while (!rdy(sel) && n < 30) begin tick(); n++; end
        check({nm, "_ready"}, int'(rdy(sel)), 1);
        if (sel) begin b_guess_in = g; b_guess_valid = 1'b1; end
        else     begin a_guess_in = g[11:0]; a_guess_valid = 1'b1; end
        tick();
        a_guess_valid = 1'b0;
        b_guess_valid = 1'b0;
    endtask

    task automatic score(input bit sel, input logic [23:0] g, input string nm,
                         input int er, input int ew);
        int lat = 0;
        offer(sel, g, nm);
        while (!sv(sel) && lat < 40) begin tick(); lat++; end
        check({nm, "_latency"}, lat, sel ? 2 * NB + 1 : 2 * NA + 1);
        check({nm, "_red"},   sel ? int'(b_red)   : int'(a_red),   er);
        check({nm, "_white"}, sel ? int'(b_white) : int'(a_white), ew);
    endtask

    typedef struct {
        logic [23:0] code;
        logic [23:0] guess;
        int          red;
        int          white;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w, bad, exp_gc, exp_win, exp_lose;
        logic [23:0] code, g;

        tbl[0] = '{p4(1,2,3,4), p4(1,2,3,4), 4, 0};
        tbl[1] = '{p4(1,1,2,2), p4(2,2,1,1), 0, 4};
        tbl[2] = '{p4(1,1,2,3), p4(1,2,1,1), 1, 2};
        tbl[3] = '{p4(1,2,3,4), p4(4,3,2,1), 0, 4};
        tbl[4] = '{p4(1,1,1,2), p4(1,1,1,1), 3, 0};
        tbl[5] = '{p4(3,3,3,3), p4(3,0,0,3), 2, 0};
        tbl[6] = '{p4(5,6,5,6), p4(6,5,6,5), 0, 4};
        tbl[7] = '{p4(1,2,3,4), p4(1,3,2,5), 1, 2};

        // Reset state
        repeat (3) tick();
        check("rst_red", int'(a_red), 0);
        check("rst_white", int'(a_white), 0);
        check("rst_score_valid", int'(a_score_valid), 0);
        check("rst_guess_count", int'(a_gc), 0);
        check("rst_win_lose", int'({a_win, a_lose}), 0);
        check("rst_busy_ready", int'({a_busy, a_guess_ready}), 0);
        resetn = 1'b1;
        tick();
        a_guess_valid = 1'b1;
        repeat (3) tick();
        check("idle_ignores_guess", int'({a_busy, a_score_valid, a_guess_ready}), 0);
        a_guess_valid = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            load_code(0, tbl[i].code);
            score(0, tbl[i].guess, $sformatf("tbl%0d", i), tbl[i].red, tbl[i].white);
            check($sformatf("tbl%0d_win", i), int'(a_win), (tbl[i].red == NA) ? 1 : 0);
            check($sformatf("tbl%0d_gc", i), int'(a_gc), 1);
            check($sformatf("tbl%0d_ready", i), int'(a_guess_ready), (tbl[i].red == NA) ? 0 : 1);
        end

        // Lose after MAX_GUESSES misses; further guesses ignored
        load_code(0, p4(7,6,5,4));
        for (int i = 0; i < MG; i++) begin
            score(0, p4(0,0,0,0), $sformatf("lose%0d", i), 0, 0);
            check($sformatf("lose%0d_gc", i), int'(a_gc), i + 1);
            check($sformatf("lose%0d_flag", i), int'(a_lose), (i == MG - 1) ? 1 : 0);
        end
        check("lose_win_clear", int'(a_win), 0);
        bad = 0;
        a_guess_valid = 1'b1;
        repeat (15) begin
            tick();
            if (a_busy || a_score_valid || a_guess_ready) bad++;
        end
        a_guess_valid = 1'b0;
        check("over_ignores_guess", bad, 0);
        check("over_gc_held", int'(a_gc), MG);

        // Abort mid-WHITE with a new code
        load_code(0, p4(1,2,3,4));
        score(0, p4(1,2,0,0), "abort_pre", 2, 0);
        offer(0, p4(4,3,2,1), "abort");
        repeat (NA + 2) tick();
        check("abort_in_white_busy", int'(a_busy), 1);
        code = p4(5,5,6,6);
        load_code(0, code);
        check("abort_ready", int'(a_guess_ready), 1);
        check("abort_busy", int'(a_busy), 0);
        check("abort_gc", int'(a_gc), 0);
        check("abort_red_white", int'({a_red, a_white}), 0);
        bad = 0;
        repeat (2 * NA + 4) begin
            if (a_score_valid) bad++;
            tick();
        end
        check("abort_no_score", bad, 0);
        ref_score(code, p4(6,5,5,6), NA, CA, r, w);
        score(0, p4(6,5,5,6), "abort_post", r, w);
        check("abort_post_gc", int'(a_gc), 1);

        // Reset while in DONE
        offer(0, p4(5,5,1,1), "rstdone");
        repeat (2 * NA) tick();
        check("rstdone_not_busy", int'(a_busy), 0);
        resetn = 1'b0;
        tick();
        check("rstdone_red_white", int'({a_red, a_white}), 0);
        check("rstdone_sv", int'(a_score_valid), 0);
        check("rstdone_gc", int'(a_gc), 0);
        check("rstdone_flags", int'({a_win, a_lose, a_busy, a_guess_ready}), 0);
        resetn = 1'b1;
        tick();
        check("rstdone_idle", int'(a_guess_ready), 0);

        // Wider instance: NUM_PEGS=6, COLOR_W=4
        load_code(1, 24'h543210);
        score(1, 24'h012345, "sweep", 0, 6);
        for (int i = 0; i < 8; i++) begin
            code = rnd_vec(NB, CB, (i % 2) ? 3 : 15);
            g    = (i == 5) ? code : rnd_vec(NB, CB, (i % 2) ? 3 : 15);
            ref_score(code, g, NB, CB, r, w);
            load_code(1, code);
            score(1, g, $sformatf("brnd%0d", i), r, w);
            check($sformatf("brnd%0d_win", i), int'(b_win), (r == NB) ? 1 : 0);
        end

        // Randomized games on the default instance
        code = rnd_vec(NA, CA, 7);
        load_code(0, code);
        exp_gc = 0;
        for (int it = 0; it < 60; it++) begin
            g = (it % 7 == 3) ? code : rnd_vec(NA, CA, (it % 2) ? 3 : 7);
            ref_score(code, g, NA, CA, r, w);
            score(0, g, $sformatf("rnd%0d", it), r, w);
            exp_gc++;
            exp_win  = (r == NA) ? 1 : 0;
            exp_lose = (!exp_win && exp_gc == MG) ? 1 : 0;
            check($sformatf("rnd%0d_gc", it), int'(a_gc), exp_gc);
            check($sformatf("rnd%0d_win", it), int'(a_win), exp_win);
            check($sformatf("rnd%0d_lose", it), int'(a_lose), exp_lose);
            if (exp_win || exp_lose) begin
                check($sformatf("rnd%0d_over_ready", it), int'(a_guess_ready), 0);
                code = rnd_vec(NA, CA, (it % 3 == 0) ? 3 : 7);
                load_code(0, code);
                exp_gc = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
